// File: rtl/ascii_to_scancode_tx_if.sv
// Byte-wide handshake bundle for the ASCII-to-scancode transmitter.
// The master side supplies characters and accepts scancode bytes.
// The slave side is the transmitter itself.
interface ascii_to_scancode_tx_if;
    logic [7:0] ascii_in;
    logic       ascii_valid;
    logic       ascii_ready;
    logic [7:0] code_out;
    logic       code_valid;
    logic       code_ready;
    logic       unsupported;

    modport master (
        output ascii_in,
        output ascii_valid,
        output code_ready,
        input  ascii_ready,
        input  code_out,
        input  code_valid,
        input  unsupported
    );

    modport slave (
        input  ascii_in,
        input  ascii_valid,
        input  code_ready,
        output ascii_ready,
        output code_out,
        output code_valid,
        output unsupported
    );
endinterface

// File: rtl/ascii_to_scancode_tx.sv
// ASCII to PS/2 Set-2 scancode transmitter.
// It takes one character at a time and emits the byte stream a keyboard would
// send to type that character: an optional shift make, the key make, the key
// break, and an optional shift break. An optional idle gap can follow every byte.
module ascii_to_scancode_tx #(
    parameter int unsigned GAP_CYCLES   = 0,
    parameter logic [7:0]  BREAK_PREFIX = 8'hF0,
    parameter logic [7:0]  SHIFT_CODE   = 8'h12
) (
    input logic                   clk,
    input logic                   rst_n,
    ascii_to_scancode_tx_if.slave bus_io
);

    typedef enum logic [2:0] {
        IDLE,
        SH_MK,
        KEY_MK,
        KEY_PFX,
        KEY_BRK,
        SH_PFX,
        SH_BRK,
        GAP
    } state_e;

    // Letter keys A..Z. Upper and lower case share one table.
    localparam logic [7:0] LETTER_CODES [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
    };

    // Digit keys 0..9 on the main row.
    localparam logic [7:0] DIGIT_CODES [10] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
    };

    // The gap counter is loaded with N-1 so that exactly N idle cycles elapse.
    localparam logic [7:0] GAP_LOAD = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    state_e     stateQ;
    state_e     resumeQ;
    logic [7:0] keyQ;
    logic       shiftQ;
    logic [7:0] gapCntQ;
    logic [7:0] codeQ;
    logic       validQ;
    logic       readyQ;
    logic       unsupQ;

    logic       mapHitD;
    logic       mapShiftD;
    logic [7:0] mapKeyD;
    logic [4:0] letterIdxD;
    state_e     nextStepD;
    logic [7:0] nextByteD;
    logic [7:0] resumeByteD;

    // Returns the step that follows the byte currently being sent. IDLE means the sequence is done.
    function automatic state_e stepAfter(input state_e cur, input logic shifted);
        state_e nxt;
        nxt = IDLE;
        case (cur)
            SH_MK:   nxt = KEY_MK;
            KEY_MK:  nxt = KEY_PFX;
            KEY_PFX: nxt = KEY_BRK;
            KEY_BRK: nxt = shifted ? SH_PFX : IDLE;
            SH_PFX:  nxt = SH_BRK;
            default: nxt = IDLE;
        endcase
        return nxt;
    endfunction

    // Returns the byte that is presented while a given step is active.
    function automatic logic [7:0] byteFor(input state_e st, input logic [7:0] key);
        logic [7:0] b;
        b = 8'h00;
        case (st)
            SH_MK, SH_BRK:   b = SHIFT_CODE;
            KEY_MK, KEY_BRK: b = key;
            KEY_PFX, SH_PFX: b = BREAK_PREFIX;
            default:         b = 8'h00;
        endcase
        return b;
    endfunction

    // Character lookup: decides whether the offered character is typeable, which key it uses,
    // and whether shift must be held around it.
    always_comb begin
        mapHitD    = 1'b1;
        mapShiftD  = 1'b0;
        mapKeyD    = 8'h00;
        letterIdxD = bus_io.ascii_in[4:0] - 5'd1;
        if (bus_io.ascii_in >= 8'h41 && bus_io.ascii_in <= 8'h5A) begin
            mapShiftD = 1'b1;
            mapKeyD   = LETTER_CODES[letterIdxD];
        end else if (bus_io.ascii_in >= 8'h61 && bus_io.ascii_in <= 8'h7A) begin
            mapKeyD = LETTER_CODES[letterIdxD];
        end else if (bus_io.ascii_in >= 8'h30 && bus_io.ascii_in <= 8'h39) begin
            mapKeyD = DIGIT_CODES[bus_io.ascii_in[3:0]];
        end else begin
            case (bus_io.ascii_in)
                8'h20:   mapKeyD = 8'h29;
                8'h0A:   mapKeyD = 8'h5A;
                8'h08:   mapKeyD = 8'h66;
                8'h2E:   mapKeyD = 8'h49;
                default: mapHitD = 1'b0;
            endcase
        end
    end

    // Sequencing helpers: what follows the current byte, and what to present when a gap ends.
    always_comb begin
        nextStepD   = stepAfter(stateQ, shiftQ);
        nextByteD   = byteFor(nextStepD, keyQ);
        resumeByteD = byteFor(resumeQ, keyQ);
    end

    // Main sequencer: accepts characters, walks the make/break byte sequence and times the gaps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ  <= IDLE;
            resumeQ <= IDLE;
            keyQ    <= 8'h00;
            shiftQ  <= 1'b0;
            gapCntQ <= 8'd0;
            codeQ   <= 8'h00;
            validQ  <= 1'b0;
            readyQ  <= 1'b0;
            unsupQ  <= 1'b0;
        end else begin
            unsupQ <= 1'b0;
            case (stateQ)
                IDLE: begin
                    if (readyQ && bus_io.ascii_valid) begin
                        if (mapHitD) begin
                            keyQ   <= mapKeyD;
                            shiftQ <= mapShiftD;
                            readyQ <= 1'b0;
                            validQ <= 1'b1;
                            codeQ  <= mapShiftD ? SHIFT_CODE : mapKeyD;
                            stateQ <= mapShiftD ? SH_MK : KEY_MK;
                        end else begin
                            unsupQ <= 1'b1;
                        end
                    end else begin
                        readyQ <= 1'b1;
                    end
                end
                GAP: begin
                    if (gapCntQ == 8'd0) begin
                        if (resumeQ == IDLE) begin
                            readyQ <= 1'b1;
                        end else begin
                            validQ <= 1'b1;
                            codeQ  <= resumeByteD;
                        end
                        stateQ <= resumeQ;
                    end else begin
                        gapCntQ <= gapCntQ - 8'd1;
                    end
                end
                default: begin
                    if (validQ && bus_io.code_ready) begin
                        if (GAP_CYCLES == 0) begin
                            if (nextStepD == IDLE) begin
                                validQ <= 1'b0;
                                readyQ <= 1'b1;
                            end else begin
                                codeQ <= nextByteD;
                            end
                            stateQ <= nextStepD;
                        end else begin
                            validQ  <= 1'b0;
                            resumeQ <= nextStepD;
                            gapCntQ <= GAP_LOAD;
                            stateQ  <= GAP;
                        end
                    end
                end
            endcase
        end
    end

    assign bus_io.ascii_ready = readyQ;
    assign bus_io.code_out    = codeQ;
    assign bus_io.code_valid  = validQ;
    assign bus_io.unsupported = unsupQ;

endmodule

// File: doc/ascii_to_scancode_tx.md
Name: ascii_to_scancode_tx

Overview:
- Reverse direction of the keyboard scancode-to-ASCII decode path.
- Accepts one ASCII character at a time and emits the PS/2 Set-2 byte stream a keyboard would send to type it: optional shift make, key make, key break, optional shift break.
- Drives the keyboard input path from the CPU or bench (loopback/self-test, keystroke injection).
- Byte-wide valid/ready on both sides.

Parameters:
- GAP_CYCLES, default 0: idle cycles with code_valid low inserted after every emitted byte, including the last; 0..255.
- BREAK_PREFIX, default 8'hF0: break prefix byte.
- SHIFT_CODE, default 8'h12: left-shift scancode.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst_n, input, 1: synchronous reset, active low.
- ascii_in, input, 8: character to send.
- ascii_valid, input, 1: ascii_in valid.
- ascii_ready, output, 1: block accepts a character this cycle.
- code_out, output, 8: scancode byte.
- code_valid, output, 1: code_out valid.
- code_ready, input, 1: sink accepts code_out.
- unsupported, output, 1: one-cycle pulse when an accepted character has no mapping.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-low.
- Clock/reset: single clock clk; rst_n sampled only on the rising edge of clk.
- Registered outputs and reset values: all outputs are registered. Reset: ascii_ready=0, code_valid=0, code_out=8'h00, unsupported=0, state=IDLE, gap counter=0.
- First cycle after rst_n goes high: ascii_ready=1.
- Mapping, uppercase (shift required): 0x41-0x5A map to 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A (A..Z).
- Mapping, lowercase: 0x61-0x7A use the same codes, no shift.
- Mapping, no shift: 0x30-0x39 -> 45 16 1E 26 25 2E 36 3D 3E 46; 0x20->29; 0x0A->5A; 0x08->66; 0x2E->49.
- All other values are unsupported.
- Accept: on an edge with ascii_valid && ascii_ready, latch the character.
  - Unsupported: ascii_ready stays 1, unsupported=1 for exactly one cycle, no bytes emitted.
  - Supported: ascii_ready<=0, code_valid<=1, code_out<=first byte. Latency is 1 cycle from the accept edge.
- Sequences:
  - Shifted: SHIFT_CODE, K, BREAK_PREFIX, K, BREAK_PREFIX, SHIFT_CODE (6 bytes).
  - Unshifted: K, BREAK_PREFIX, K (3 bytes).
- States: IDLE, SH_MK, KEY_MK, KEY_PFX, KEY_BRK, SH_PFX, SH_BRK, GAP.
  - Shifted path: IDLE->SH_MK->KEY_MK->KEY_PFX->KEY_BRK->SH_PFX->SH_BRK->IDLE.
  - Unshifted path: IDLE->KEY_MK->KEY_PFX->KEY_BRK->IDLE.
  - GAP is entered between any two steps when GAP_CYCLES>0.
- Byte handshake: a transfer occurs on an edge with code_valid && code_ready.
  - code_out and code_valid are held stable until the transfer.
  - code_valid never drops without a transfer, except on reset.
- After a transfer:
  - GAP_CYCLES==0: next byte loaded on the same edge, so code_valid stays 1 (back-to-back). After the last byte, code_valid<=0 and ascii_ready<=1 on the same edge.
  - GAP_CYCLES==N>0: code_valid<=0, counter runs N cycles, then the next byte is presented. After the last byte, ascii_ready rises after the N gap cycles.
- Characters arriving while ascii_ready=0 are not consumed; upstream holds them.
- code_ready asserted while code_valid=0 has no effect.
- Reset mid-sequence: sequence abandoned with no break bytes sent; outputs return to reset values on the reset edge.

Test Plan:
- GAP=0, code_ready=1, 'a'(0x61) after reset -> code_out 1C,F0,1C on 3 consecutive cycles starting 1 cycle after accept; ascii_ready high the cycle after the last transfer.
- 'A'(0x41) -> 12,1C,F0,1C,F0,12 back-to-back, 6 cycles code_valid=1; unsupported stays 0.
- '5'(0x35) with code_ready low 4 cycles after first present -> code_out held at 2E with code_valid=1 throughout, then 2E,F0,2E transferred; no byte lost or duplicated.
- '#'(0x23) then 0x00 -> unsupported one-cycle pulse each, code_valid never asserts, ascii_ready remains 1.
- GAP_CYCLES=2, '\n'(0x0A) -> 5A, 2 cycles valid low, F0, 2 low, 5A, 2 low, then ascii_ready=1.
- 'Z'(0x5A), rst_n low for 1 cycle right after the 12 transfer -> all outputs at reset values; after release ascii_ready=1 next cycle and no further bytes emitted.
